piso_tx: RTL and testbench
==========================

# piso_tx

Parallel-in, serial-out transmitter: the sending end of the team's parallel register path. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock with a frame-start strobe, an optional even-parity bit and a completion pulse. It sits between parallel register banks and any single-wire serial link or downstream serial-in capture stage. It supports gapless back-to-back frames.

## Interface
- WIDTH, 4, data word width in bits (≥2)
- MSB_FIRST, 0, 0: bit 0 sent first; 1: bit WIDTH-1 sent first
- PARITY_EN, 1, 1: append one even-parity bit after the data bits; 0: no parity bit

- clk  input  1  system clock, rising-edge
- rst  input  1  asynchronous, active-high reset
- par_in  input  WIDTH  word to transmit, sampled only on acceptance
- load_valid  input  1  source offers par_in
- load_ready  output  1  block can accept a word this cycle
- ser_out  output  1  serial data bit
- ser_valid  output  1  ser_out carries a frame bit this cycle
- frame_start  output  1  first bit of a frame is on ser_out
- done  output  1  last bit of a frame (data or parity) is on ser_out
- busy  output  1  a frame is in progress (equals ser_valid)

## Operation
- States: IDLE, SHIFT, PARITY (PARITY exists only when PARITY_EN=1).
- Acceptance: a word is accepted on a rising edge where load_valid && load_ready.
- load_ready is combinational:
  - 1 in IDLE.
  - 1 during the final cycle of a frame (done=1).
  - 0 otherwise.
  - Forced 0 while rst is high.
- On acceptance:
  - Latch par_in into the shift register.
  - Clear the bit counter.
  - Latch parity = ^par_in.
  - Enter SHIFT.
- SHIFT: one data bit per cycle in the MSB_FIRST order, with ser_valid=1. frame_start=1 on counter 0 only.
  - After bit WIDTH-1, go to PARITY if PARITY_EN=1, otherwise to IDLE.
  - A new acceptance in the final cycle goes directly to SHIFT instead.
- PARITY: one cycle, ser_out = latched parity, so the total count of ones in the frame is even. Next state is IDLE, or SHIFT on a new acceptance.
- done=1 for exactly one cycle, on the last bit of each frame.
- load_valid while load_ready=0 is ignored; the source must hold its word. Changes to par_in after acceptance have no effect.
- Idle line: ser_out=0 whenever ser_valid=0.
- Reset values (asynchronous, immediate on rst rising):
  - state IDLE
  - ser_out 0, ser_valid 0, frame_start 0, done 0, busy 0
  - shift register 0, counter 0
- Reset mid-frame aborts the frame: no done pulse and no partial completion. Operation resumes normally on the first edge after rst falls.

## Timing
- All outputs except load_ready are registered.
- Latency: word accepted at edge k → first bit on ser_out in the cycle after edge k, with frame_start=1.
- Frame length: WIDTH + PARITY_EN cycles of ser_valid=1.
- Back-to-back: acceptance in the done cycle starts the next frame on the following cycle, with zero idle cycles between frames.
- Throughput: one word per WIDTH + PARITY_EN cycles.
- Counter width: $clog2(WIDTH). The counter wraps to 0 only on acceptance or on return to IDLE.

## Test plan
- Reset: hold rst=1 across edges → ser_out=0, ser_valid=0, done=0, busy=0, load_ready=0. Release rst → load_ready=1 in the next cycle.
- Single frame (WIDTH=4, LSB first, parity on): accept 4'b1010.
  - ser_out sequence 0,1,0,1,0 over 5 cycles.
  - frame_start on cycle 1, done on cycle 5.
  - Then idle with ser_out=0 and load_ready=1.
- Back-to-back: accept 4'b1010, then present 4'b1110 with load_valid held.
  - The second word is accepted in the done cycle.
  - ser_out = 0,1,0,1,0 then 0,1,1,1,1, with no gap.
  - frame_start and done pulse once per frame.
- Ignored load: during bit 2 of the 4'b1010 frame, pulse load_valid with 4'b0001 → not accepted, and the frame output is unchanged.
- Mid-frame reset: assert rst asynchronously during bit 2 of 4'b1110.
  - Outputs go to 0 immediately, with no done pulse.
  - After release, accepting 4'b0011 yields 1,1,0,0,0.
- Config MSB_FIRST=1, PARITY_EN=0: accept 4'b1011 → ser_out 1,0,1,1, done on the 4th bit, 4-cycle frame.

Source files
------------

// File: rtl/piso_tx_if.sv
// piso_tx_if: word handshake and serial output bundle for piso_tx.
//   par_in      - word to transmit (master -> slave)
//   load_valid  - master offers par_in
//   load_ready  - slave can accept a word this cycle
//   ser_out     - serial data bit
//   ser_valid   - ser_out carries a frame bit
//   frame_start - first bit of a frame is on ser_out
//   done        - last bit of a frame is on ser_out
//   busy        - frame in progress (same as ser_valid)
interface piso_tx_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] par_in;
   logic             load_valid;
   logic             load_ready;
   logic             ser_out;
   logic             ser_valid;
   logic             frame_start;
   logic             done;
   logic             busy;

   modport master (
      output par_in, load_valid,
      input  load_ready, ser_out, ser_valid, frame_start, done, busy
   );

   modport slave (
      input  par_in, load_valid,
      output load_ready, ser_out, ser_valid, frame_start, done, busy
   );
endinterface

// File: rtl/piso_tx.sv
// piso_tx: parallel-in, serial-out transmitter.
// Accepts a WIDTH-bit word on a valid/ready handshake and shifts it out one
// bit per clock, optionally followed by an even-parity bit. A new word may be
// accepted in the last cycle of a frame, giving gapless back-to-back frames.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset
//   bus - piso_tx_if slave: par_in/load_valid in, load_ready (combinational),
//         ser_out/ser_valid/frame_start/done/busy out (registered)
module piso_tx #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b0,
   parameter bit PARITY_EN = 1'b1
) (
   input  logic      clk,
   input  logic      rst,
   piso_tx_if.slave  bus
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shreg_nxt;
   logic [CW-1:0]    cnt;
   logic             par_bit;
   logic             ser_out_r;
   logic             ser_valid_r;
   logic             frame_start_r;
   logic             done_r;
   logic             load_ready;
   logic             accept;
   logic             load_head;
   logic             shift_head;

   // shreg holds the whole word with the bit currently on ser_out at the
   // head; it rotates rather than shifts so every bit stays in use.
   always_comb begin
      load_ready = !rst && ((state == IDLE) || done_r);
      accept     = bus.load_valid && load_ready;
      if (MSB_FIRST) begin
         shreg_nxt  = {shreg[WIDTH-2:0], shreg[WIDTH-1]};
         load_head  = bus.par_in[WIDTH-1];
         shift_head = shreg_nxt[WIDTH-1];
      end else begin
         shreg_nxt  = {shreg[0], shreg[WIDTH-1:1]};
         load_head  = bus.par_in[0];
         shift_head = shreg_nxt[0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         shreg         <= '0;
         cnt           <= '0;
         par_bit       <= 1'b0;
         ser_out_r     <= 1'b0;
         ser_valid_r   <= 1'b0;
         frame_start_r <= 1'b0;
         done_r        <= 1'b0;
      end else if (accept) begin
         state         <= SHIFT;
         shreg         <= bus.par_in;
         cnt           <= '0;
         par_bit       <= ^bus.par_in;
         ser_out_r     <= load_head;
         ser_valid_r   <= 1'b1;
         frame_start_r <= 1'b1;
         done_r        <= 1'b0;
      end else begin
         case (state)
            SHIFT: begin
               frame_start_r <= 1'b0;
               if (cnt == CW'(WIDTH - 1)) begin
                  if (PARITY_EN) begin
                     // counter holds at WIDTH-1 through the parity cycle
                     state     <= PARITY;
                     ser_out_r <= par_bit;
                     done_r    <= 1'b1;
                  end else begin
                     state       <= IDLE;
                     cnt         <= '0;
                     ser_out_r   <= 1'b0;
                     ser_valid_r <= 1'b0;
                     done_r      <= 1'b0;
                  end
               end else begin
                  cnt       <= cnt + 1'b1;
                  shreg     <= shreg_nxt;
                  ser_out_r <= shift_head;
                  // without parity the last data bit is the last frame bit
                  done_r    <= !PARITY_EN && (cnt == CW'(WIDTH - 2));
               end
            end
            PARITY: begin
               state         <= IDLE;
               cnt           <= '0;
               ser_out_r     <= 1'b0;
               ser_valid_r   <= 1'b0;
               frame_start_r <= 1'b0;
               done_r        <= 1'b0;
            end
            default: begin
               state         <= IDLE;
               cnt           <= '0;
               ser_out_r     <= 1'b0;
               ser_valid_r   <= 1'b0;
               frame_start_r <= 1'b0;
               done_r        <= 1'b0;
            end
         endcase
      end
   end

   assign bus.load_ready  = load_ready;
   assign bus.ser_out     = ser_out_r;
   assign bus.ser_valid   = ser_valid_r;
   assign bus.frame_start = frame_start_r;
   assign bus.done        = done_r;
   assign bus.busy        = ser_valid_r;

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: self-checking bench for piso_tx.
// dut_a: WIDTH=4, LSB first, parity on. dut_b: WIDTH=4, MSB first, no parity.
// Observed vectors are {ser_out, ser_valid, frame_start, done, busy, load_ready}.
module tb_piso_tx;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   piso_tx_if #(.WIDTH(4)) ifa ();
   piso_tx_if #(.WIDTH(4)) ifb ();

   piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0), .PARITY_EN(1'b1)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa.slave)
   );

   piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1), .PARITY_EN(1'b0)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb.slave)
   );

   always #5 clk = ~clk;

   // ---------------- reference model (dut_a configuration) ----------------
   localparam int unsigned LEN_A = 5;   // 4 data bits + parity
   bit          m_v;                    // a frame bit is on the line
   logic [3:0]  m_w;                    // word of the frame in flight
   int unsigned m_i;                    // index of the frame bit on the line

   // bit k of a frame: data bits in the chosen order, then even parity
   function automatic logic frame_bit(input logic [3:0] w, input int unsigned k,
                                      input bit msb);
      if (k < 4) return msb ? w[3-k] : w[k];
      return ($countones(w) % 2) == 1;
   endfunction

   function automatic bit model_ready();
      return !m_v || (m_i == LEN_A - 1);
   endfunction

   function automatic logic [5:0] exp_a();
      if (!m_v) return 6'b000001;
      return {frame_bit(m_w, m_i, 1'b0), 1'b1, (m_i == 0), (m_i == LEN_A - 1),
              1'b1, model_ready()};
   endfunction

   function automatic logic [5:0] obs_a();
      return {ifa.ser_out, ifa.ser_valid, ifa.frame_start, ifa.done, ifa.busy,
              ifa.load_ready};
   endfunction

   function automatic logic [5:0] obs_b();
      return {ifb.ser_out, ifb.ser_valid, ifb.frame_start, ifb.done, ifb.busy,
              ifb.load_ready};
   endfunction

   // Drive dut_a for one clock (called at a falling edge, returns at the next)
   // and advance the model by the same clock.
   task automatic step_a(input logic lv, input logic [3:0] pi, output bit acc);
      bit rdy;
      rdy = model_ready();
      ifa.load_valid = lv;
      ifa.par_in     = pi;
      @(posedge clk);
      acc = lv && rdy;
      if (acc) begin
         m_v = 1'b1;
         m_w = pi;
         m_i = 0;
      end else if (m_v) begin
         if (m_i == LEN_A - 1) m_v = 1'b0;
         else m_i++;
      end
      @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      ifa.load_valid = 1'b1;
      ifa.par_in     = 4'hF;
      ifb.load_valid = 1'b1;
      ifb.par_in     = 4'hF;
      repeat (2) @(posedge clk);
      @(negedge clk);
      if (obs_a() !== 6'b000000) begin
         errors++;
         $display("FAIL reset_a: got %b expected %b", obs_a(), 6'b000000);
      end
      checks++;
      if (obs_b() !== 6'b000000) begin
         errors++;
         $display("FAIL reset_b: got %b expected %b", obs_b(), 6'b000000);
      end
      checks++;
      ifa.load_valid = 1'b0;
      ifb.load_valid = 1'b0;
      rst = 1'b0;
      m_v = 1'b0;
      @(negedge clk);
      if (obs_a() !== 6'b000001) begin
         errors++;
         $display("FAIL reset_release_a: got %b expected %b", obs_a(), 6'b000001);
      end
      checks++;
      if (obs_b() !== 6'b000001) begin
         errors++;
         $display("FAIL reset_release_b: got %b expected %b", obs_b(), 6'b000001);
      end
      checks++;
   endtask

   task automatic test_single();
      bit acc;
      for (int i = 0; i < 9; i++) begin
         step_a((i == 1), 4'b1010, acc);
         if (obs_a() !== exp_a()) begin
            errors++;
            $display("FAIL single[%0d]: got %b expected %b", i, obs_a(), exp_a());
         end
         checks++;
      end
   endtask

   task automatic test_back_to_back();
      bit acc;
      int starts = 0;
      int dones  = 0;
      bit second = 1'b0;
      step_a(1'b1, 4'b1010, acc);
      for (int i = 0; i < 14; i++) begin
         if (obs_a() !== exp_a()) begin
            errors++;
            $display("FAIL b2b[%0d]: got %b expected %b", i, obs_a(), exp_a());
         end
         checks++;
         starts += int'(ifa.frame_start);
         dones  += int'(ifa.done);
         step_a(!second, 4'b1110, acc);
         if (acc) second = 1'b1;
      end
      if (starts != 2 || dones != 2) begin
         errors++;
         $display("FAIL b2b_pulses: got starts=%0d dones=%0d expected 2 and 2",
                  starts, dones);
      end
      checks++;
   endtask

   task automatic test_ignored_load();
      bit acc;
      step_a(1'b1, 4'b1010, acc);
      for (int i = 0; i < 8; i++) begin
         if (obs_a() !== exp_a()) begin
            errors++;
            $display("FAIL ignored[%0d]: got %b expected %b", i, obs_a(), exp_a());
         end
         checks++;
         // bit 2 is on the line at i==2; a load then must be ignored
         step_a((i == 2), (i == 2) ? 4'b0001 : 4'b1010, acc);
      end
   endtask

   task automatic test_mid_reset();
      bit acc;
      step_a(1'b1, 4'b1110, acc);
      step_a(1'b0, 4'b1110, acc);
      step_a(1'b0, 4'b1110, acc);
      #2 rst = 1'b1;
      #1;
      if (obs_a() !== 6'b000000) begin
         errors++;
         $display("FAIL midrst_async: got %b expected %b", obs_a(), 6'b000000);
      end
      checks++;
      m_v = 1'b0;
      @(negedge clk);
      if (obs_a() !== 6'b000000) begin
         errors++;
         $display("FAIL midrst_hold: got %b expected %b", obs_a(), 6'b000000);
      end
      checks++;
      rst = 1'b0;
      for (int i = 0; i < 7; i++) begin
         step_a((i == 0), 4'b0011, acc);
         if (obs_a() !== exp_a()) begin
            errors++;
            $display("FAIL midrst_after[%0d]: got %b expected %b", i, obs_a(), exp_a());
         end
         checks++;
      end
   endtask

   task automatic test_msb_nopar();
      logic [3:0] w;
      logic [5:0] e;
      w = 4'b1011;
      ifb.load_valid = 1'b1;
      ifb.par_in     = w;
      if (ifb.load_ready !== 1'b1) begin
         errors++;
         $display("FAIL msb_ready: got %b expected 1", ifb.load_ready);
      end
      checks++;
      @(posedge clk);
      #1 ifb.load_valid = 1'b0;
      ifb.par_in = 4'b0000;
      for (int unsigned k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k < 4) e = {frame_bit(w, k, 1'b1), 1'b1, (k == 0), (k == 3), 1'b1, (k == 3)};
         else e = 6'b000001;
         if (obs_b() !== e) begin
            errors++;
            $display("FAIL msb_nopar[%0d]: got %b expected %b", k, obs_b(), e);
         end
         checks++;
      end
   endtask

   task automatic test_random();
      bit acc;
      for (int i = 0; i < 300; i++) begin
         step_a(($urandom_range(0, 3) != 0), 4'($urandom), acc);
         if (obs_a() !== exp_a()) begin
            errors++;
            $display("FAIL random[%0d]: got %b expected %b", i, obs_a(), exp_a());
         end
         checks++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_ignored_load();
      test_mid_reset();
      test_msb_nopar();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
